rf_write_arbiter: RTL and testbench



---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
// Requester IDs map to bit positions in req_valid / req_ready.
package rf_arb_pkg;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  function automatic logic [15:0] onehot16(input logic [3:0] addr);
    return 16'h0001 << addr;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority selector: first valid requester at or after i_ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port with a registered
// write stage and a combinational pending-write mask for hazard stalls.
module rf_write_arbiter #(
  parameter int NREQ = rf_arb_pkg::NREQ,
  parameter int AW   = rf_arb_pkg::AW,
  parameter int DW   = rf_arb_pkg::DW
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              RF,
  output logic [AW-1:0]     C,
  output logic [DW-1:0]     PC,
  output logic [15:0]       pend
);

  import rf_arb_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_rf;
  logic [AW-1:0]   r_c;
  logic [DW-1:0]   r_pc;

  logic [NREQ-1:0] w_valid_eff;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic [PW-1:0]   w_ptr_next;
  logic [15:0]     w_pend;

  // Reset also masks grants so nothing is offered while the stage is cleared.
  assign w_valid_eff = (hold || !Rst_n) ? '0 : req_valid;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .i_valid (w_valid_eff),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_ptr_next = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ptr <= '0;
      r_rf  <= 1'b0;
      r_c   <= '0;
      r_pc  <= '0;
    end else begin
      r_rf <= w_any;
      if (w_any) begin
        r_ptr <= w_ptr_next;
        r_c   <= w_sel_addr;
        r_pc  <= w_sel_data;
      end
    end
  end

  always_comb begin
    w_pend = r_rf ? onehot16(r_c) : 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) w_pend = w_pend | onehot16(req_addr[i*AW +: AW]);
    end
  end

  assign RF   = r_rf;
  assign C    = r_c;
  assign PC   = r_pc;
  assign pend = w_pend;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, round-robin,
// same-register race, hold, and reset while a write is in flight.
module tb_rf_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        RF;
  logic [3:0]  C;
  logic [31:0] PC;
  logic [15:0] pend;

  logic [31:0] mem [16] = '{default: 32'h0};

  int n_total = 0;
  int n_pass  = 0;

  rf_write_arbiter dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .RF        (RF),
    .C         (C),
    .PC        (PC),
    .pend      (pend)
  );

  always #5 Clk = ~Clk;

  // Register file: captures the registered strobe at each rising edge.
  always @(posedge Clk) if (RF) mem[C] <= PC;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[i*4 +: 4] = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic out(input string tag, input logic rf, input logic [3:0] c, input logic [31:0] pc);
    chk({tag, "_rf"}, RF, rf);
    chk({tag, "_c"}, C, c);
    chk({tag, "_pc"}, PC, pc);
  endtask

  logic [2:0]  rr_ready [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [3:0]  rr_c     [6] = '{4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd4};
  logic [31:0] rr_pc    [6] = '{32'hA0, 32'hB1, 32'hC2, 32'hA0, 32'hB1, 32'hC2};

  initial begin
    Rst_n = 1'b0; hold = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    #1;
    out("rst", 1'b0, 4'd0, 32'h0);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_pend", pend, 16'h0000);
    set_req(0, 1'b1, 4'd1, 32'hA0);
    set_req(1, 1'b1, 4'd2, 32'hB1);
    set_req(2, 1'b1, 4'd4, 32'hC2);
    #1;
    chk("rst_ready_allvalid", req_ready, 3'b000);
    @(negedge Clk);
    out("rst_hold", 1'b0, 4'd0, 32'h0);
    Rst_n = 1'b1;
    #1;
    chk("rel_ready", req_ready, 3'b001);

    // Round robin under full load
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      #1;
      out($sformatf("rr%0d", k), 1'b1, rr_c[k], rr_pc[k]);
      chk($sformatf("rr%0d_ready", k), req_ready, rr_ready[k]);
    end
    req_valid = '0;
    #1;
    chk("drain_ready", req_ready, 3'b000);
    chk("drain_pend", pend, 16'h0010);
    @(negedge Clk);
    #1;
    out("idle", 1'b0, 4'd4, 32'hC2);
    chk("idle_pend", pend, 16'h0000);

    // Single request from requester 1, ptr=0
    set_req(1, 1'b1, 4'd5, 32'hAA);
    #1;
    chk("single_ready", req_ready, 3'b010);
    chk("single_pend_req", pend, 16'h0020);
    @(negedge Clk);
    set_req(1, 1'b0, 4'd5, 32'hAA);
    #1;
    out("single_w", 1'b1, 4'd5, 32'hAA);
    chk("single_ready_off", req_ready, 3'b000);
    chk("single_pend_rf", pend, 16'h0020);
    @(negedge Clk);
    #1;
    chk("single_rf_off", RF, 1'b0);
    chk("single_pend_off", pend, 16'h0000);
    chk("mem5", mem[5], 32'hAA);

    // Same-register race, ptr=2
    set_req(0, 1'b1, 4'd3, 32'h11);
    set_req(2, 1'b1, 4'd3, 32'h22);
    #1;
    chk("race_ready0", req_ready, 3'b100);
    chk("race_pend", pend, 16'h0008);
    @(negedge Clk);
    set_req(2, 1'b0, 4'd3, 32'h22);
    #1;
    out("race_w0", 1'b1, 4'd3, 32'h22);
    chk("race_ready1", req_ready, 3'b001);
    @(negedge Clk);
    set_req(0, 1'b0, 4'd3, 32'h11);
    #1;
    out("race_w1", 1'b1, 4'd3, 32'h11);
    chk("race_ready_off", req_ready, 3'b000);
    @(negedge Clk);
    #1;
    out("race_idle", 1'b0, 4'd3, 32'h11);
    chk("mem3_final", mem[3], 32'h11);

    // hold with req0 valid, ptr=1
    hold = 1'b1;
    set_req(0, 1'b1, 4'd6, 32'h66);
    #1;
    chk("hold_ready", req_ready, 3'b000);
    chk("hold_pend", pend, 16'h0040);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("hold%0d_rf", k), RF, 1'b0);
      chk($sformatf("hold%0d_ready", k), req_ready, 3'b000);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready", req_ready, 3'b001);
    @(negedge Clk);
    set_req(0, 1'b0, 4'd6, 32'h66);
    #1;
    out("unhold_w", 1'b1, 4'd6, 32'h66);

    // hold with all valid, ptr must stay at 1
    hold = 1'b1;
    set_req(0, 1'b1, 4'd7, 32'h70);
    set_req(1, 1'b1, 4'd8, 32'h81);
    set_req(2, 1'b1, 4'd9, 32'h92);
    #1;
    chk("hold2_ready", req_ready, 3'b000);
    repeat (2) @(negedge Clk);
    #1;
    chk("hold2_rf", RF, 1'b0);
    hold = 1'b0;
    #1;
    chk("hold2_ptr", req_ready, 3'b010);
    @(negedge Clk);
    set_req(1, 1'b0, 4'd8, 32'h81);
    #1;
    out("hold2_w", 1'b1, 4'd8, 32'h81);
    chk("hold2_next", req_ready, 3'b100);

    // Reset while R8 write is in flight (ptr=2)
    Rst_n = 1'b0;
    #1;
    out("midrst", 1'b0, 4'd0, 32'h0);
    chk("midrst_ready", req_ready, 3'b000);
    @(negedge Clk);
    #1;
    chk("midrst_mem8", mem[8], 32'h0);
    Rst_n = 1'b1;
    #1;
    chk("midrst_ptr0", req_ready, 3'b001);
    @(negedge Clk);
    #1;
    out("midrst_w", 1'b1, 4'd7, 32'h70);
    chk("midrst_next", req_ready, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
